// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipeline_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } hazState_t;

  localparam int unsigned REG_W     = 5;
  localparam int unsigned CNT_W_DEF = 16;
  localparam int unsigned REM_W     = 3;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  // Load in EX writes a register the ID instruction reads; $0 never counts.
  function automatic logic loadUseHazard(
    input logic             memRead,
    input logic [REG_W-1:0] writeReg,
    input logic [REG_W-1:0] rs,
    input logic [REG_W-1:0] rt,
    input logic             usesRt
  );
    return memRead && (writeReg != REG_ZERO) &&
           ((writeReg == rs) || (usesRt && (writeReg == rt)));
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low reset.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use stall and taken-branch flush sequencer for the 5-stage pipeline.
// Performance counters are built only when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int unsigned STALL_CYCLES = 1,
  parameter int unsigned CNT_W        = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_write_reg,
  input  logic             mem_branch_taken,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  hazState_t        state, nextState;
  logic [REM_W-1:0] remaining, nextRemaining;
  logic             hz;
  logic             stallInc, flushInc;

  assign hz = loadUseHazard(ex_mem_read, ex_write_reg, id_rs, id_rt, id_uses_rt);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= RUN;
      remaining <= '0;
    end else begin
      state     <= nextState;
      remaining <= nextRemaining;
    end
  end

  // Decisions take effect on the same edge; reset forces free-running enables.
  always_comb begin
    nextState     = state;
    nextRemaining = remaining;
    pc_write      = 1'b1;
    ifid_write    = 1'b1;
    ifid_flush    = 1'b0;
    idex_flush    = 1'b0;
    exmem_flush   = 1'b0;
    stallInc      = 1'b0;
    flushInc      = 1'b0;
    if (rst) begin
      unique case (state)
        RUN, STALL: begin
          if (mem_branch_taken) begin
            ifid_flush    = 1'b1;
            idex_flush    = 1'b1;
            exmem_flush   = 1'b1;
            flushInc      = 1'b1;
            nextRemaining = '0;
            nextState     = FLUSH;
          end else if ((state == STALL) || hz) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
            stallInc   = 1'b1;
            if (state == STALL) begin
              nextRemaining = remaining - REM_W'(1);
              if (remaining == REM_W'(1)) nextState = RUN;
            end else if (STALL_CYCLES > 1) begin
              nextRemaining = REM_W'(STALL_CYCLES - 1);
              nextState     = STALL;
            end
          end
        end
        FLUSH:   nextState = RUN;
        default: nextState = RUN;
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (stallInc),
    .count(stall_count)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (flushInc),
    .count(flush_count)
  );
`else
  logic unusedPerf;
  assign unusedPerf  = stallInc ^ flushInc;
  assign stall_count = '0;
  assign flush_count = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: two configurations share one stimulus stream.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [4:0] id_rs, id_rt, ex_write_reg;
  logic       id_uses_rt, ex_mem_read, mem_branch_taken;

  logic        pcA, ifidA, ifidFA, idexFA, exmemFA;
  logic        pcB, ifidB, ifidFB, idexFB, exmemFB;
  logic [15:0] stallA, flushA;
  logic [3:0]  stallB, flushB;

  hazard_ctrl #(.STALL_CYCLES(1), .CNT_W(16)) dutA (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_write_reg(ex_write_reg),
    .mem_branch_taken(mem_branch_taken),
    .pc_write(pcA), .ifid_write(ifidA), .ifid_flush(ifidFA), .idex_flush(idexFA),
    .exmem_flush(exmemFA), .stall_count(stallA), .flush_count(flushA)
  );

  hazard_ctrl #(.STALL_CYCLES(3), .CNT_W(4)) dutB (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_write_reg(ex_write_reg),
    .mem_branch_taken(mem_branch_taken),
    .pc_write(pcB), .ifid_write(ifidB), .ifid_flush(ifidFB), .idex_flush(idexFB),
    .exmem_flush(exmemFB), .stall_count(stallB), .flush_count(flushB)
  );

  typedef struct {
    logic [4:0] ctl [2];   // {pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush}
    int         sCnt [2];
    int         fCnt [2];
  } exp_t;

  exp_t q [$];

  // Reference model: stall cycles still owed, whether the next cycle is the post-branch bubble.
  int cfgStall [2] = '{1, 3};
  int cfgMax   [2] = '{65535, 15};
  int owed     [2];
  bit postBr   [2];
  int mStall   [2];
  int mFlush   [2];

  int nPass  = 0;
  int nTotal = 0;

  task automatic modelStep(input int k, output logic [4:0] ctl);
    bit hz;
    hz = ex_mem_read && (ex_write_reg != 0) &&
         ((ex_write_reg == id_rs) || (id_uses_rt && (ex_write_reg == id_rt)));
    if (!rst) begin
      ctl = 5'b11000;
      owed[k] = 0; postBr[k] = 0; mStall[k] = 0; mFlush[k] = 0;
    end else if (postBr[k]) begin
      ctl = 5'b11000;
      postBr[k] = 0;
    end else if (mem_branch_taken) begin
      ctl = 5'b11111;
      owed[k] = 0; postBr[k] = 1;
      if (mFlush[k] < cfgMax[k]) mFlush[k]++;
    end else if (owed[k] > 0 || hz) begin
      ctl = 5'b00010;
      owed[k] = (owed[k] > 0) ? owed[k] - 1 : cfgStall[k] - 1;
      if (mStall[k] < cfgMax[k]) mStall[k]++;
    end else begin
      ctl = 5'b11000;
    end
  endtask

  task automatic cyc(input logic r, input logic br, input logic mr, input logic ur,
                     input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] wr);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; mem_branch_taken = br; ex_mem_read = mr; id_uses_rt = ur;
    id_rs = rs; id_rt = rt; ex_write_reg = wr;
    for (int k = 0; k < 2; k++) begin
`ifdef HAZARD_PERF_CNT_EN
      e.sCnt[k] = mStall[k];
      e.fCnt[k] = mFlush[k];
`else
      e.sCnt[k] = 0;
      e.fCnt[k] = 0;
`endif
      modelStep(k, e.ctl[k]);
    end
    q.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTotal++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: outputs are combinational, so every cycle presents a response.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check("A.ctl", 32'({pcA, ifidA, ifidFA, idexFA, exmemFA}), 32'(e.ctl[0]));
      check("A.stall_count", 32'(stallA), 32'(e.sCnt[0]));
      check("A.flush_count", 32'(flushA), 32'(e.fCnt[0]));
      check("B.ctl", 32'({pcB, ifidB, ifidFB, idexFB, exmemFB}), 32'(e.ctl[1]));
      check("B.stall_count", 32'(stallB), 32'(e.sCnt[1]));
      check("B.flush_count", 32'(flushB), 32'(e.fCnt[1]));
    end
  end

  function automatic logic [4:0] pickReg();
    int sel;
    sel = int'($urandom_range(0, 3));
    case (sel)
      0:       return 5'd0;
      1:       return 5'd8;
      2:       return 5'd9;
      default: return 5'($urandom_range(0, 31));
    endcase
  endfunction

  initial begin
    rst = 1'b0; mem_branch_taken = 1'b0; ex_mem_read = 1'b0; id_uses_rt = 1'b0;
    id_rs = '0; id_rt = '0; ex_write_reg = '0;
    repeat (2) @(posedge clk);

    // Reset held with branch and hazard present
    cyc(0, 1, 1, 0, 8, 0, 8);
    cyc(0, 1, 1, 0, 8, 0, 8);
    // Load-use on rs, then idle
    cyc(1, 0, 1, 0, 8, 0, 8);
    cyc(1, 0, 0, 0, 8, 0, 8);
    repeat (3) cyc(1, 0, 0, 0, 0, 0, 0);
    // $0 and rt cases
    cyc(1, 0, 1, 1, 0, 0, 0);
    cyc(1, 0, 1, 0, 1, 9, 9);
    cyc(1, 0, 1, 1, 1, 9, 9);
    repeat (3) cyc(1, 0, 0, 0, 0, 0, 0);
    // Branch and hazard together, hazard held through FLUSH
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 1, 0, 8, 0, 8);
    cyc(1, 0, 1, 0, 8, 0, 8);
    cyc(1, 0, 0, 0, 0, 0, 0);
    // Branch held for 40 cycles: 20 flushes saturate the 4-bit counter
    cyc(0, 0, 0, 0, 0, 0, 0);
    repeat (40) cyc(1, 1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    // Branch arriving mid-stall
    cyc(1, 0, 1, 1, 3, 4, 4);
    cyc(1, 1, 0, 0, 0, 0, 0);
    repeat (2) cyc(1, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 63) != 0), ($urandom_range(0, 7) == 0),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          pickReg(), pickReg(), pickReg());
    end

    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    $display("%0d/%0d checks passed", nPass, nTotal);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Stall/flush sequencer for the 5-stage MIPS pipeline (IF/ID/EX/MEM/WB).
- Detects load-use hazards between ID and EX and freezes PC and IF/ID for STALL_CYCLES cycles while bubbling ID/EX.
- Branches resolve in MEM. On a taken branch it flushes IF/ID, ID/EX and EX/MEM, which removes the three wrong-path instructions.
- Sits beside the pipeline registers and drives their write-enable and flush controls.

Parameters:
- STALL_CYCLES, 1: bubbles inserted per load-use hazard (1..7).
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous, active-low reset
- id_rs  in  5  rs field of the instruction in ID
- id_rt  in  5  rt field of the instruction in ID
- id_uses_rt  in  1  ID instruction reads rt (R-type, beq, sw)
- ex_mem_read  in  1  instruction in EX is a load
- ex_write_reg  in  5  destination register of the instruction in EX
- mem_branch_taken  in  1  branch in MEM is taken (branch & zero)
- pc_write  out  1  PC load enable
- ifid_write  out  1  IF/ID load enable
- ifid_flush  out  1  zero IF/ID on the next edge
- idex_flush  out  1  zero ID/EX control bits on the next edge
- exmem_flush  out  1  zero EX/MEM control bits on the next edge
- stall_count  out  CNT_W  total stall cycles inserted
- flush_count  out  CNT_W  total taken-branch flushes

Behaviour:
- Clock and reset:
  - Single clock domain.
  - When rst==0 at a posedge: state=RUN, stall counter=0, stall_count=0, flush_count=0.
  - During reset: pc_write=1, ifid_write=1, all flushes=0.
- Hazard term:
  - hz = ex_mem_read && ex_write_reg!=0 && (ex_write_reg==id_rs || (id_uses_rt && ex_write_reg==id_rt)).
  - Register $0 never causes a hazard.
- FSM states: RUN, STALL, FLUSH.
- RUN:
  - If mem_branch_taken:
    - Assert ifid_flush, idex_flush and exmem_flush this cycle.
    - pc_write=1 so the branch target loads.
    - Go to FLUSH.
    - flush_count += 1.
  - Else if hz:
    - pc_write=0, ifid_write=0, idex_flush=1.
    - stall_count += 1.
    - If STALL_CYCLES>1, load remaining=STALL_CYCLES-1 and go to STALL; otherwise stay in RUN.
  - Else all enables=1 and all flushes=0.
- STALL:
  - pc_write=0, ifid_write=0, idex_flush=1.
  - stall_count += 1 and remaining -= 1; go to RUN when remaining reaches 0.
  - A mem_branch_taken in STALL takes priority: perform the RUN branch action, abandon the stall and go to FLUSH.
- FLUSH:
  - Lasts one cycle. No flushes asserted and all enables=1.
  - hz is ignored, because ID holds a bubble.
  - Then return to RUN.
- Priority: branch flush > load-use stall.
- Outputs are combinational from state + inputs. Zero latency: the decision applies at the same clock edge.
- Counters saturate at all-ones; they do not wrap.
- Reset arriving mid-STALL or mid-FLUSH returns to RUN on the same edge and discards remaining.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined: stall_count and flush_count are implemented as described.
- Undefined: the counters are not instantiated and both outputs are tied to 0. State machine behaviour is identical in both builds.

Decomposition:
- Shared package (pipeline_pkg):
  - State encoding: RUN=2'd0, STALL=2'd1, FLUSH=2'd2.
  - REG_ZERO=5'd0.
  - CNT_W default.
- One natural sub-module: sat_counter (parameterised width; inc, rst inputs; saturating), instantiated twice under HAZARD_PERF_CNT_EN.

Test Plan:
- Reset: rst=0 for 2 cycles with mem_branch_taken=1 and hz conditions applied → pc_write=1, ifid_write=1, all flushes=0, counters=0.
- Load-use on rs, STALL_CYCLES=1: ex_mem_read=1, ex_write_reg=8, id_rs=8 → one cycle with pc_write=0, ifid_write=0, idex_flush=1; next cycle (ex_mem_read=0) normal operation; stall_count=1.
- Register $0 and rt cases:
  - ex_write_reg=0, id_rs=0 → no stall.
  - id_rt=9, ex_write_reg=9, id_uses_rt=0 → no stall.
  - Same case with id_uses_rt=1 → stall.
- STALL_CYCLES=3: a hazard pulse held for 1 cycle → exactly 3 consecutive stall cycles, then RUN; stall_count=3.
- Branch vs stall priority: mem_branch_taken=1 together with hz=1 in RUN → all three flushes=1, pc_write=1, no stall. The following cycle (FLUSH, hz still 1) → no stall. flush_count=1, stall_count=0.
- Saturation and macro off:
  - CNT_W=4: 20 flushes → flush_count=4'hF.
  - HAZARD_PERF_CNT_EN undefined → both counts stay 0 while control outputs are unchanged.
